// File: rtl/alu_pkg.sv
// Shared ALU function codes and flag bit positions for the picoMIPS datapath.
package alu_pkg;

   localparam int unsigned FUNC_W = 3;
   localparam int unsigned FLAG_W = 4;

   localparam logic [FUNC_W-1:0] RA   = 3'b000;
   localparam logic [FUNC_W-1:0] RB   = 3'b001;
   localparam logic [FUNC_W-1:0] RADD = 3'b010;
   localparam logic [FUNC_W-1:0] RSUB = 3'b011;
   localparam logic [FUNC_W-1:0] RAND = 3'b100;
   localparam logic [FUNC_W-1:0] ROR  = 3'b101;
   localparam logic [FUNC_W-1:0] RXOR = 3'b110;
   localparam logic [FUNC_W-1:0] RMUL = 3'b111;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/function request and registered result/flags between decoder and ALU.
interface alu_if
   import alu_pkg::*;
#(
   parameter int unsigned n = 8
);

   logic [n-1:0]      a;
   logic [n-1:0]      b;
   logic [FUNC_W-1:0] func;
   logic [n-1:0]      result;
   logic [FLAG_W-1:0] flags;

   modport master (output a, output b, output func, input result, input flags);
   modport slave  (input a, input b, input func, output result, output flags);

endinterface

// File: rtl/alu_core.sv
// Combinational result and N/Z/C/V flag computation for one ALU operation.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned n = 8
) (
   input  logic [n-1:0]      a,
   input  logic [n-1:0]      b,
   input  logic [FUNC_W-1:0] func,
   output logic [n-1:0]      result_c,
   output logic [FLAG_W-1:0] flags_c
);

   localparam int unsigned PW = 2 * n;

   logic [n:0]             sum;
   logic [n:0]             diff;
   logic signed [PW-1:0]   prod;
   logic                   carry;
   logic                   ovf;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign prod = $signed({{n{a[n-1]}}, a}) * $signed({{n{b[n-1]}}, b});

   // Q1.(n-1) multiply keeps p[2n-2:n-1]; the top two bits disagree only on -1 x -1.
   always_comb begin
      result_c = '0;
      flags_c  = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      case (func)
         RA:   result_c = a;
         RB:   result_c = b;
         RADD: begin
            result_c = sum[n-1:0];
            carry    = sum[n];
            ovf      = (a[n-1] == b[n-1]) && (sum[n-1] != a[n-1]);
         end
         RSUB: begin
            result_c = diff[n-1:0];
            carry    = diff[n];
            ovf      = (a[n-1] != b[n-1]) && (diff[n-1] != a[n-1]);
         end
         RAND: result_c = a & b;
         ROR:  result_c = a | b;
         RXOR: result_c = a ^ b;
         RMUL: begin
            result_c = n'(prod >>> (n - 1));
            ovf      = prod[PW-1] ^ prod[PW-2];
         end
         default: result_c = '0;
      endcase
      flags_c[FLAG_N] = result_c[n-1];
      flags_c[FLAG_Z] = (result_c == '0);
      flags_c[FLAG_C] = carry;
      flags_c[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu.sv
// Registered picoMIPS ALU: one-cycle latency from operands/func to result and flags.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned n = 8
) (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);

   logic [n-1:0]      result_c;
   logic [FLAG_W-1:0] flags_c;

   alu_core #(.n(n)) u_core (
      .a        (bus.a),
      .b        (bus.b),
      .func     (bus.func),
      .result_c (result_c),
      .flags_c  (flags_c)
   );

   // Synchronous reset wins over the operation presented on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.result <= '0;
         bus.flags  <= '0;
      end else begin
         bus.result <= result_c;
         bus.flags  <= flags_c;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors plus randomized ops against an integer model.
module tb_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_if #(.n(8)) bus ();

   alu #(.n(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [11:0] exp_out;
   bit          have_exp = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: flags and result from signed/unsigned integer arithmetic on 8-bit values.
   function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
      int ua = int'(a);
      int ub = int'(b);
      int sa = a[7] ? ua - 256 : ua;
      int sb = b[7] ? ub - 256 : ub;
      int r  = 0;
      int t  = 0;
      bit c  = 1'b0;
      bit v  = 1'b0;
      case (f)
         RA:   r = ua;
         RB:   r = ub;
         RADD: begin
            t = ua + ub;
            r = t % 256;
            c = (t > 255);
            v = (sa + sb > 127) || (sa + sb < -128);
         end
         RSUB: begin
            r = (ua - ub + 256) % 256;
            c = (ua < ub);
            v = (sa - sb > 127) || (sa - sb < -128);
         end
         RAND: r = ua & ub;
         ROR:  r = ua | ub;
         RXOR: r = ua ^ ub;
         default: begin
            t = sa * sb;
            r = (t >>> 7) & 255;
            v = (t >= 16384) || (t < -16384);
         end
      endcase
      return {(r >= 128), (r == 0), c, v, 8'(r)};
   endfunction

   // One cycle: outputs must hold across the input change, then update on the edge.
   task automatic step(input string tag, input logic r, input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic [2:0] f, input logic [11:0] want, input bit use_model);
      logic [11:0] nxt;
      @(negedge clk);
      rst_n    = r;
      bus.a    = a_i;
      bus.b    = b_i;
      bus.func = f;
      #1;
      if (have_exp) check({tag, "_hold"}, {20'd0, bus.flags, bus.result}, {20'd0, exp_out});
      if (!r)             nxt = 12'h000;
      else if (use_model) nxt = model(a_i, b_i, f);
      else                nxt = want;
      @(posedge clk);
      #1;
      check({tag, "_res"},   {24'd0, bus.result}, {24'd0, nxt[7:0]});
      check({tag, "_flags"}, {28'd0, bus.flags},  {28'd0, nxt[11:8]});
      exp_out  = nxt;
      have_exp = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.a    = 8'h04;
      bus.b    = 8'h03;
      bus.func = RADD;
      exp_out  = 12'h000;

      step("rst0",   1'b0, 8'h04, 8'h03, RADD, 12'h000, 1'b0);
      step("rst1",   1'b0, 8'h04, 8'h03, RADD, 12'h000, 1'b0);
      step("rel",    1'b1, 8'h04, 8'h03, RADD, 12'h007, 1'b0);

      step("b2b_add", 1'b1, 8'h04, 8'h03, RADD, 12'h007, 1'b0);
      step("b2b_sub", 1'b1, 8'h04, 8'h03, RSUB, 12'h001, 1'b0);
      step("b2b_mul", 1'b1, 8'h04, 8'h03, RMUL, 12'h400, 1'b0);

      step("add_ovf",  1'b1, 8'h7F, 8'h01, RADD, 12'h980, 1'b0);
      step("add_cry",  1'b1, 8'hFF, 8'h01, RADD, 12'h600, 1'b0);
      step("sub_brw",  1'b1, 8'h03, 8'h04, RSUB, 12'hAFF, 1'b0);

      step("mul_pos",  1'b1, 8'h40, 8'h40, RMUL, 12'h020, 1'b0);
      step("mul_ovf",  1'b1, 8'h80, 8'h80, RMUL, 12'h980, 1'b0);
      step("mul_neg",  1'b1, 8'hC0, 8'h40, RMUL, 12'h8E0, 1'b0);

      step("and",  1'b1, 8'hF0, 8'h3C, RAND, 12'h030, 1'b0);
      step("or",   1'b1, 8'hF0, 8'h3C, ROR,  12'h8FC, 1'b0);
      step("xor",  1'b1, 8'hF0, 8'h3C, RXOR, 12'h8CC, 1'b0);
      step("pa",   1'b1, 8'hF0, 8'h3C, RA,   12'h8F0, 1'b0);
      step("pb",   1'b1, 8'hF0, 8'h3C, RB,   12'h03C, 1'b0);

      step("mid_add0", 1'b1, 8'h04, 8'h03, RADD, 12'h007, 1'b0);
      step("mid_rst",  1'b0, 8'h04, 8'h03, RADD, 12'h000, 1'b0);
      step("mid_add1", 1'b1, 8'h04, 8'h03, RADD, 12'h007, 1'b0);

      for (int i = 0; i < 400; i++) begin
         logic [7:0] ra = 8'($urandom);
         logic [7:0] rb = 8'($urandom);
         logic [2:0] rf = 3'($urandom);
         logic       rr = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
         if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hFF;
         step("rnd", rr, ra, rb, rf, 12'h000, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
